// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl
//   Host-side debug controller for the pipelined CPU. Gates the CPU clock to run,
//   single-step or halt the core, stops it on a PC breakpoint, and while halted dumps
//   PC, x0..x31 and a data-memory window as a tagged word stream on a valid/ready port.
//
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   cmd_run/step/halt/dump      one-cycle command pulses (priority halt > dump > step > run)
//   bp_en, bp_addr              PC breakpoint enable and address
//   pc                          CPU IF-stage PC
//   rrd0 / rra0                 register debug read data / address (combinational read)
//   drd0 / dra0                 data-memory debug read data / word index
//   cpu_clk_en                  CPU clock enable
//   out_valid/ready/data        dump stream handshake and word
//   out_kind, out_idx           word tag: 0=PC, 1=register, 2=memory; register no. or offset
//   busy, halted                busy in RUN/STEP/DUMP, halted in IDLE
//   bp_hit, dump_done           one-cycle status pulses

module cpu_debug_ctrl #(
  parameter int unsigned DM_BASE  = 0,
  parameter int unsigned DM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_run,
  input  logic        cmd_step,
  input  logic        cmd_halt,
  input  logic        cmd_dump,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] rrd0,
  input  logic [31:0] drd0,
  output logic        cpu_clk_en,
  output logic [4:0]  rra0,
  output logic [31:0] dra0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_kind,
  output logic [9:0]  out_idx,
  output logic        busy,
  output logic        halted,
  output logic        bp_hit,
  output logic        dump_done
);

  // Last dump item: PC (0), registers (1..32), memory words (33..32+DM_WORDS).
  localparam logic [10:0] LastItem = 11'(32 + DM_WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StStep,
    StDumpAddr,
    StDumpCap,
    StDumpOut
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] item_q, item_d;
  logic        armed_q;
  logic [4:0]  rra0_q, rra0_d;
  logic [31:0] dra0_q, dra0_d;
  logic [31:0] out_data_q, out_data_d;
  logic [1:0]  out_kind_q, out_kind_d;
  logic [9:0]  out_idx_q, out_idx_d;
  logic        out_valid_q, out_valid_d;
  logic        bp_hit_q, bp_hit_d;
  logic        dump_done_q, dump_done_d;

  logic        bp_stop;
  logic        item_is_pc;
  logic        item_is_reg;
  logic [4:0]  reg_num;
  logic [9:0]  reg_idx;
  logic [9:0]  mem_idx;
  logic [31:0] mem_addr;

  // armed_q is only high when the previous cycle was also RUN, so the first RUN cycle
  // always lets the CPU move off a breakpoint PC.
  assign bp_stop = armed_q & bp_en & (pc == bp_addr);

  assign item_is_pc  = (item_q == 11'd0);
  assign item_is_reg = (item_q <= 11'd32);
  // item 32 wraps to 31 in five bits, which is the intended register number.
  assign reg_num     = item_q[4:0] - 5'd1;
  assign reg_idx     = item_q[9:0] - 10'd1;
  assign mem_idx     = item_q[9:0] - 10'd33;
  assign mem_addr    = 32'(DM_BASE) + {21'b0, item_q} - 32'd33;

  always_comb begin
    state_d     = state_q;
    item_d      = item_q;
    rra0_d      = rra0_q;
    dra0_d      = dra0_q;
    out_data_d  = out_data_q;
    out_kind_d  = out_kind_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    bp_hit_d    = 1'b0;
    dump_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_halt) begin
          state_d = StIdle;
        end else if (cmd_dump) begin
          state_d = StDumpAddr;
          item_d  = 11'd0;
        end else if (cmd_step) begin
          state_d = StStep;
        end else if (cmd_run) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (cmd_halt || bp_stop) begin
          state_d = StIdle;
        end
        bp_hit_d = bp_stop;
      end

      StStep: begin
        state_d = StIdle;
      end

      StDumpAddr: begin
        if (!item_is_pc) begin
          if (item_is_reg) begin
            rra0_d = reg_num;
          end else begin
            dra0_d = mem_addr;
          end
        end
        state_d = StDumpCap;
      end

      StDumpCap: begin
        if (item_is_pc) begin
          out_data_d = pc;
          out_kind_d = 2'd0;
          out_idx_d  = 10'd0;
        end else if (item_is_reg) begin
          out_data_d = rrd0;
          out_kind_d = 2'd1;
          out_idx_d  = reg_idx;
        end else begin
          out_data_d = drd0;
          out_kind_d = 2'd2;
          out_idx_d  = mem_idx;
        end
        out_valid_d = 1'b1;
        state_d     = StDumpOut;
      end

      StDumpOut: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (item_q == LastItem) begin
            dump_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            item_d  = item_q + 11'd1;
            state_d = StDumpAddr;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      item_q      <= 11'd0;
      armed_q     <= 1'b0;
      rra0_q      <= 5'd0;
      dra0_q      <= 32'd0;
      out_data_q  <= 32'd0;
      out_kind_q  <= 2'd0;
      out_idx_q   <= 10'd0;
      out_valid_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      item_q      <= item_d;
      armed_q     <= (state_q == StRun);
      rra0_q      <= rra0_d;
      dra0_q      <= dra0_d;
      out_data_q  <= out_data_d;
      out_kind_q  <= out_kind_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      bp_hit_q    <= bp_hit_d;
      dump_done_q <= dump_done_d;
    end
  end

  // Gated the same cycle the breakpoint PC is seen: the instruction is fetched, not advanced.
  assign cpu_clk_en = ((state_q == StRun) & ~bp_stop) | (state_q == StStep);

  assign busy      = (state_q != StIdle);
  assign halted    = (state_q == StIdle);
  assign rra0      = rra0_q;
  assign dra0      = dra0_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_kind  = out_kind_q;
  assign out_idx   = out_idx_q;
  assign bp_hit    = bp_hit_q;
  assign dump_done = dump_done_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
module tb_cpu_debug_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0, cmd_dump = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc;
  logic [31:0] rrd0, drd0;
  logic        cpu_clk_en;
  logic [4:0]  rra0;
  logic [31:0] dra0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_kind;
  logic [9:0]  out_idx;
  logic        busy, halted, bp_hit, dump_done;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;

  always #5 clk = ~clk;

  // CPU model: PC advances by 4 on each enabled clock; debug reads are combinational.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc <= 32'd0;
    else if (cpu_clk_en) pc <= pc + 32'd4;
  end
  assign rrd0 = 32'h100 + {27'b0, rra0};
  assign drd0 = 32'hA000 + dra0;

  always @(negedge clk) if (cpu_clk_en) en_cnt++;

  cpu_debug_ctrl #(.DM_BASE(4), .DM_WORDS(2)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt), .cmd_dump(cmd_dump),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .rrd0(rrd0), .drd0(drd0),
    .cpu_clk_en(cpu_clk_en), .rra0(rra0), .dra0(dra0),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_kind(out_kind), .out_idx(out_idx),
    .busy(busy), .halted(halted), .bp_hit(bp_hit), .dump_done(dump_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rstn = 1'b0;
    cmd_run = 0; cmd_step = 0; cmd_halt = 0; cmd_dump = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({cpu_clk_en, out_valid, busy, bp_hit, dump_done, halted} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 000001",
               {cpu_clk_en, out_valid, busy, bp_hit, dump_done, halted});
    end
    n_checks++;
    if ({rra0, dra0, out_data, out_kind, out_idx} !== 81'd0) begin
      n_fail++;
      $display("FAIL reset_regs got rra0=%0d dra0=%h data=%h kind=%0d idx=%0d exp all 0",
               rra0, dra0, out_data, out_kind, out_idx);
    end
  endtask

  task automatic test_step();
    int e0;
    apply_reset();
    e0 = en_cnt;
    cmd_step = 1; tick(); cmd_step = 0;
    n_checks++;
    if ({cpu_clk_en, halted, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL step_active got en/halted/busy=%b exp 101", {cpu_clk_en, halted, busy});
    end
    tick();
    n_checks++;
    if ({cpu_clk_en, halted} !== 2'b01) begin
      n_fail++;
      $display("FAIL step_done got en/halted=%b exp 01", {cpu_clk_en, halted});
    end
    repeat (3) tick();
    n_checks++;
    if (en_cnt - e0 != 1 || pc !== 32'h4) begin
      n_fail++;
      $display("FAIL step_count got %0d cycles pc=%h exp 1 cycle pc=4", en_cnt - e0, pc);
    end
  endtask

  task automatic test_run_halt();
    int e0;
    apply_reset();
    e0 = en_cnt;
    cmd_run = 1; tick(); cmd_run = 0;
    repeat (9) tick();
    cmd_halt = 1; tick(); cmd_halt = 0;
    n_checks++;
    if (halted !== 1'b1 || cpu_clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL run_halt_state got halted=%b en=%b exp 1 0", halted, cpu_clk_en);
    end
    tick();
    n_checks++;
    if (en_cnt - e0 != 10 || pc !== 32'd40) begin
      n_fail++;
      $display("FAIL run_halt_count got %0d cycles pc=%h exp 10 pc=28", en_cnt - e0, pc);
    end
  endtask

  task automatic test_breakpoint();
    bit seen = 0;
    apply_reset();
    bp_en = 1; bp_addr = 32'h0C;
    cmd_run = 1; tick(); cmd_run = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halted) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen || pc !== 32'h0C || bp_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stop got halted=%b pc=%h bp_hit=%b exp 1 0000000c 1", seen, pc, bp_hit);
    end
    tick();
    n_checks++;
    if (bp_hit !== 1'b0 || pc !== 32'h0C) begin
      n_fail++;
      $display("FAIL bp_pulse got bp_hit=%b pc=%h exp 0 0000000c", bp_hit, pc);
    end
    cmd_run = 1; tick(); cmd_run = 0;
    cmd_halt = 1; tick(); cmd_halt = 0;
    n_checks++;
    if (pc !== 32'h10 || halted !== 1'b1 || bp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_resume got pc=%h halted=%b bp_hit=%b exp 00000010 1 0",
               pc, halted, bp_hit);
    end
    bp_en = 0;
  endtask

  task automatic test_dump();
    int n = 0;
    int done_c = -1;
    logic [31:0] exp_pc, ed;
    logic [1:0]  ek;
    logic [9:0]  ei;
    apply_reset();
    repeat (3) begin cmd_step = 1; tick(); cmd_step = 0; tick(); end
    exp_pc = 32'h0C;
    out_ready = 1;
    cmd_dump = 1; tick(); cmd_dump = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (n == 0) begin ed = exp_pc; ek = 2'd0; ei = 10'd0; end
        else if (n <= 32) begin ed = 32'h100 + 32'(n - 1); ek = 2'd1; ei = 10'(n - 1); end
        else begin ed = 32'hA004 + 32'(n - 33); ek = 2'd2; ei = 10'(n - 33); end
        n_checks++;
        if (out_data !== ed || out_kind !== ek || out_idx !== ei) begin
          n_fail++;
          $display("FAIL dump_word%0d got %h/%0d/%0d exp %h/%0d/%0d",
                   n, out_data, out_kind, out_idx, ed, ek, ei);
        end
        n++;
      end
      if (dump_done) begin done_c = c; break; end
    end
    n_checks++;
    if (n != 35 || done_c != 105) begin
      n_fail++;
      $display("FAIL dump_length got %0d words done at %0d exp 35 words done at 105", n, done_c);
    end
    @(negedge clk);
    n_checks++;
    if (dump_done !== 1'b0 || halted !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_end got done=%b halted=%b valid=%b exp 0 1 0",
               dump_done, halted, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int hold = 0, x5 = 0, nw = 0;
    bit done = 0;
    apply_reset();
    out_ready = 0;
    cmd_dump = 1; tick(); cmd_dump = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (dump_done) begin done = 1; break; end
      if (out_valid) begin
        if (out_kind == 2'd1 && out_idx == 10'd5 && hold < 20) begin
          out_ready = 0;
          hold++;
          n_checks++;
          if (out_data !== 32'h105) begin
            n_fail++;
            $display("FAIL bp_hold%0d got %h exp 00000105", hold, out_data);
          end
        end else begin
          out_ready = 1;
          nw++;
          if (out_kind == 2'd1 && out_idx == 10'd5) x5++;
        end
      end else begin
        out_ready = 0;
      end
    end
    n_checks++;
    if (!done || x5 != 1 || hold != 20 || nw != 35) begin
      n_fail++;
      $display("FAIL backpressure got done=%b x5=%0d hold=%0d words=%0d exp 1 1 20 35",
               done, x5, hold, nw);
    end
  endtask

  task automatic test_reset_mid_dump();
    int nw = 0;
    bit ok = 0;
    apply_reset();
    out_ready = 1;
    cmd_dump = 1; tick(); cmd_dump = 0;
    for (int c = 0; c < 100 && nw < 7; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) nw++;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    out_ready = 0;
    #1 rstn = 0;
    #1;
    n_checks++;
    if (!ok || out_valid !== 1'b0 || halted !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort got seen=%b valid=%b halted=%b busy=%b exp 1 0 1 0",
               ok, out_valid, halted, busy);
    end
    @(negedge clk);
    rstn = 1;
    out_ready = 1;
    tick();
    cmd_dump = 1; tick(); cmd_dump = 0;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok || out_kind !== 2'd0 || out_idx !== 10'd0 || out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL restart_pc got seen=%b %h/%0d/%0d exp 1 00000000/0/0",
               ok, out_data, out_kind, out_idx);
    end
    for (int c = 0; c < 200 && !dump_done; c++) @(negedge clk);
    tick();
  endtask

  task automatic test_priority();
    bit done = 0;
    apply_reset();
    out_ready = 1;
    cmd_halt = 1; cmd_dump = 1; cmd_step = 1; cmd_run = 1; tick();
    cmd_halt = 0; cmd_dump = 0; cmd_step = 0; cmd_run = 0;
    n_checks++;
    if ({halted, busy, cpu_clk_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL prio_halt got halted/busy/en=%b exp 100", {halted, busy, cpu_clk_en});
    end
    cmd_dump = 1; cmd_step = 1; cmd_run = 1; tick();
    cmd_dump = 0; cmd_step = 0; cmd_run = 0;
    cmd_halt = 1; cmd_run = 1; tick(); cmd_halt = 0; cmd_run = 0;
    n_checks++;
    if ({halted, busy, cpu_clk_en} !== 3'b010) begin
      n_fail++;
      $display("FAIL prio_dump got halted/busy/en=%b exp 010", {halted, busy, cpu_clk_en});
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (dump_done) begin done = 1; break; end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL prio_dump_done got done=0 exp 1");
    end
    tick();
    cmd_step = 1; cmd_run = 1; tick(); cmd_step = 0; cmd_run = 0;
    tick();
    n_checks++;
    if ({halted, cpu_clk_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_step got halted/en=%b exp 10", {halted, cpu_clk_en});
    end
    cmd_run = 1; tick(); cmd_run = 0;
    cmd_dump = 1; tick(); cmd_dump = 0;
    n_checks++;
    if ({busy, cpu_clk_en, out_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL run_ignores_dump got busy/en/valid=%b exp 110", {busy, cpu_clk_en, out_valid});
    end
    cmd_halt = 1; tick(); cmd_halt = 0;
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL run_halt2 got halted=%b exp 1", halted);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_halt();
    test_breakpoint();
    test_dump();
    test_backpressure();
    test_reset_mid_dump();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
